// File: rtl/main_mem_ctrl_if.sv
// rtl/main_mem_ctrl_if.sv - cache-to-memory-controller request/response bundle
//
// Purpose: groups the icache and dcache request/response signals between the
//          caches (master) and the memory controller (slave).
// Signals:
//   icache_req_valid/_block_addr, icache_flush      cache -> controller
//   icache_req_ready, icache_resp_valid/_block_data controller -> cache
//   dcache_req_valid/_type/_block_addr/_block_data  cache -> controller
//   dcache_req_ready, dcache_resp_valid/_block_data controller -> cache
interface main_mem_ctrl_if #(
    parameter int BLOCK_WIDTH      = 64,
    parameter int BLOCK_ADDR_WIDTH = 29
) ();
    logic                        icache_req_valid;
    logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr;
    logic                        icache_req_ready;
    logic                        icache_flush;
    logic                        icache_resp_valid;
    logic [BLOCK_WIDTH-1:0]      icache_resp_block_data;

    logic                        dcache_req_valid;
    logic                        dcache_req_type;
    logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr;
    logic [BLOCK_WIDTH-1:0]      dcache_req_block_data;
    logic                        dcache_req_ready;
    logic                        dcache_resp_valid;
    logic [BLOCK_WIDTH-1:0]      dcache_resp_block_data;

    modport master (
        output icache_req_valid, icache_req_block_addr, icache_flush,
        output dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        input  icache_req_ready, icache_resp_valid, icache_resp_block_data,
        input  dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
    );

    modport slave (
        input  icache_req_valid, icache_req_block_addr, icache_flush,
        input  dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        output icache_req_ready, icache_resp_valid, icache_resp_block_data,
        output dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
    );
endinterface

// File: rtl/main_mem_ctrl.sv
// rtl/main_mem_ctrl.sv - fixed-latency main-memory responder for icache and dcache
//
// Purpose: accepts one block request at a time (icache has priority), serves it
//          from a behavioural block array after MEM_LATENCY cycles, and pulses the
//          matching response. Writes commit at the end of the response cycle.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   init, init_we               preload mode / preload write strobe
//   init_block_addr/_data       preload address and data
//   bus (slave)                 icache and dcache request/response bundle
module main_mem_ctrl #(
    parameter int BLOCK_WIDTH      = 64,
    parameter int BLOCK_ADDR_WIDTH = 29,
    parameter int N_BLOCKS         = 1024,
    parameter int MEM_LATENCY      = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init,
    input  logic                        init_we,
    input  logic [BLOCK_ADDR_WIDTH-1:0] init_block_addr,
    input  logic [BLOCK_WIDTH-1:0]      init_block_data,
    main_mem_ctrl_if.slave              bus
);
    localparam int IDX_W = $clog2(N_BLOCKS);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_is_dcache;
    logic                   r_is_write;
    logic                   r_cancel;
    logic [IDX_W-1:0]       r_idx;
    logic [BLOCK_WIDTH-1:0] r_wdata;
    logic [BLOCK_WIDTH-1:0] r_mem [N_BLOCKS];

    logic                   w_i_ready;
    logic                   w_d_ready;
    logic                   w_i_accept;
    logic                   w_d_accept;
    logic                   w_accept;
    logic                   w_resp;
    logic                   w_i_resp_valid;
    logic                   w_d_resp_valid;
    logic [BLOCK_WIDTH-1:0] w_rdata;
    logic [IDX_W-1:0]       w_req_idx;

    // Upper block-address bits alias onto the array and are intentionally ignored.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{bus.icache_req_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W],
                                  bus.dcache_req_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W],
                                  init_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W]};

    assign w_i_ready  = (r_state == S_IDLE) & ~init & ~rst;
    assign w_d_ready  = w_i_ready & ~bus.icache_req_valid;
    assign w_i_accept = bus.icache_req_valid & w_i_ready;
    assign w_d_accept = bus.dcache_req_valid & w_d_ready;
    assign w_accept   = w_i_accept | w_d_accept;
    assign w_req_idx  = w_d_accept ? bus.dcache_req_block_addr[IDX_W-1:0]
                                   : bus.icache_req_block_addr[IDX_W-1:0];
    assign w_rdata    = r_mem[r_idx];

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == CNT_W'(1)) w_next_state = S_RESP;
            S_RESP: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Transaction latch, latency counter and icache cancel flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_cancel <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt       <= CNT_W'(MEM_LATENCY - 1);
                    r_is_dcache <= w_d_accept;
                    r_is_write  <= w_d_accept & bus.dcache_req_type;
                    r_idx       <= w_req_idx;
                    r_wdata     <= bus.dcache_req_block_data;
                    r_cancel    <= w_i_accept & bus.icache_flush;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (bus.icache_flush & ~r_is_dcache) r_cancel <= 1'b1;
                end
                default: r_cancel <= 1'b0;
            endcase
        end
    end

    // Block array: no reset; a write is lost if rst hits its response cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init & init_we) r_mem[init_block_addr[IDX_W-1:0]] <= init_block_data;
            if ((r_state == S_RESP) & r_is_write) r_mem[r_idx] <= r_wdata;
        end
    end

    // Outputs; a flush during the response cycle itself also suppresses the pulse.
    always_comb begin
        w_resp         = (r_state == S_RESP) & ~rst;
        w_i_resp_valid = w_resp & ~r_is_dcache & ~r_cancel & ~bus.icache_flush;
        w_d_resp_valid = w_resp & r_is_dcache;
        bus.icache_req_ready       = w_i_ready;
        bus.dcache_req_ready       = w_d_ready;
        bus.icache_resp_valid      = w_i_resp_valid;
        bus.icache_resp_block_data = w_i_resp_valid ? w_rdata : '0;
        bus.dcache_resp_valid      = w_d_resp_valid;
        bus.dcache_resp_block_data = w_d_resp_valid ? (r_is_write ? r_wdata : w_rdata) : '0;
    end
endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb/tb_main_mem_ctrl.sv - scoreboard bench for main_mem_ctrl (latency 10 and latency 1)
module tb_main_mem_ctrl;
    localparam int BW  = 64;
    localparam int BAW = 29;
    localparam int NB  = 1024;

    typedef struct {
        bit          ic;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    logic init;
    logic init_we;
    logic [BAW-1:0] init_block_addr;
    logic [BW-1:0]  init_block_data;

    int   tests;
    int   fails;
    int   cyc;
    exp_t q0[$];
    exp_t q1[$];

    logic [BAW-1:0] pre_a [5] = '{29'd5, 29'd1, 29'd2, 29'd3, 29'd9};
    logic [BW-1:0]  pre_d [5] = '{64'h1111_2222_3333_4444, 64'hAAAA_0000_0000_0001,
                                  64'hBBBB_0000_0000_0002, 64'hCCCC_0000_0000_0003,
                                  64'h9999_0000_0000_0009};

    main_mem_ctrl_if #(.BLOCK_WIDTH(BW), .BLOCK_ADDR_WIDTH(BAW)) bus0 ();
    main_mem_ctrl_if #(.BLOCK_WIDTH(BW), .BLOCK_ADDR_WIDTH(BAW)) bus1 ();

    main_mem_ctrl #(.BLOCK_WIDTH(BW), .BLOCK_ADDR_WIDTH(BAW), .N_BLOCKS(NB), .MEM_LATENCY(10)) u_dut (
        .clk(clk), .rst(rst), .init(init), .init_we(init_we),
        .init_block_addr(init_block_addr), .init_block_data(init_block_data), .bus(bus0));

    main_mem_ctrl #(.BLOCK_WIDTH(BW), .BLOCK_ADDR_WIDTH(BAW), .N_BLOCKS(NB), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .init(init), .init_we(init_we),
        .init_block_addr(init_block_addr), .init_block_data(init_block_data), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int d, input bit ic, input logic [63:0] data, input int c);
        exp_t e;
        e.ic = ic; e.data = data; e.cyc = c;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic iv, input logic [63:0] idat,
                       input logic dv, input logic [63:0] ddat);
        exp_t e;
        bit   have;
        have = 0;
        if (d == 0 && q0.size() > 0) begin e = q0[0]; have = 1; end
        if (d == 1 && q1.size() > 0) begin e = q1[0]; have = 1; end
        if (iv !== 1'b1) check($sformatf("dut%0d_i_data_idle", d), idat, 64'd0);
        if (dv !== 1'b1) check($sformatf("dut%0d_d_data_idle", d), ddat, 64'd0);
        if (iv === 1'b1 || dv === 1'b1) begin
            if (!have) begin
                check($sformatf("dut%0d_unexpected_resp", d), {62'd0, iv, dv}, 64'd0);
            end else begin
                check($sformatf("dut%0d_resp_port", d), {63'd0, iv}, {63'd0, e.ic});
                check($sformatf("dut%0d_resp_cycle", d), 64'(cyc), 64'(e.cyc));
                check($sformatf("dut%0d_resp_data", d), iv ? idat : ddat, e.data);
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end else if (have && e.cyc <= cyc) begin
            check($sformatf("dut%0d_missing_resp", d), {63'd0, iv | dv}, 64'd1);
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    // Sample the current cycle (inputs driven at posedge+1), then advance one cycle.
    task automatic step(input int ei = -1, input int ed = -1, input int ei1 = -1);
        #2;
        if (ei  >= 0) check("dut0_icache_req_ready", {63'd0, bus0.icache_req_ready}, 64'(ei));
        if (ed  >= 0) check("dut0_dcache_req_ready", {63'd0, bus0.dcache_req_ready}, 64'(ed));
        if (ei1 >= 0) check("dut1_icache_req_ready", {63'd0, bus1.icache_req_ready}, 64'(ei1));
        mon(0, bus0.icache_resp_valid, bus0.icache_resp_block_data,
               bus0.dcache_resp_valid, bus0.dcache_resp_block_data);
        mon(1, bus1.icache_resp_valid, bus1.icache_resp_block_data,
               bus1.dcache_resp_valid, bus1.dcache_resp_block_data);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_n(input int n, input int ei, input int ed);
        for (int k = 0; k < n; k++) step(ei, ed);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rst = 1'b1; init = 1'b0; init_we = 1'b0;
        init_block_addr = '0; init_block_data = '0;
        bus0.icache_req_valid = 1'b0; bus0.icache_req_block_addr = '0; bus0.icache_flush = 1'b0;
        bus0.dcache_req_valid = 1'b0; bus0.dcache_req_type = 1'b0;
        bus0.dcache_req_block_addr = '0; bus0.dcache_req_block_data = '0;
        bus1.icache_req_valid = 1'b0; bus1.icache_req_block_addr = '0; bus1.icache_flush = 1'b0;
        bus1.dcache_req_valid = 1'b0; bus1.dcache_req_type = 1'b0;
        bus1.dcache_req_block_addr = '0; bus1.dcache_req_block_data = '0;
        @(posedge clk);
        #1;

        // Reset: no readiness, no responses
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b0;
        step(1, 1, 1);

        // Preload; a pending icache request must not be accepted during init
        init = 1'b1; init_we = 1'b1;
        for (int k = 0; k < 5; k++) begin
            init_block_addr = pre_a[k];
            init_block_data = pre_d[k];
            bus0.icache_req_valid = (k == 0);
            bus0.icache_req_block_addr = 29'd5;
            step(0, 0, 0);
        end
        init = 1'b0; init_we = 1'b0; bus0.icache_req_valid = 1'b0;
        step(1, 1, 1);

        // icache read of block 5: response at T+10, ready back at T+11
        bus0.icache_req_valid = 1'b1; bus0.icache_req_block_addr = 29'd5;
        push(0, 1, pre_d[0], cyc + 10);
        step(1, 0);
        bus0.icache_req_valid = 1'b0;
        wait_n(10, 0, 0);
        step(1, 1);

        // Simultaneous icache/dcache: icache wins, dcache accepted at T+11
        bus0.icache_req_valid = 1'b1; bus0.icache_req_block_addr = 29'd1;
        bus0.dcache_req_valid = 1'b1; bus0.dcache_req_type = 1'b0; bus0.dcache_req_block_addr = 29'd2;
        push(0, 1, pre_d[1], cyc + 10);
        step(1, 0);
        bus0.icache_req_valid = 1'b0;
        wait_n(10, 0, 0);
        push(0, 0, pre_d[2], cyc + 10);
        step(1, 1);
        bus0.dcache_req_valid = 1'b0;
        wait_n(10, 0, 0);
        step(1, 1);

        // dcache write of block 7 with echoed ack, then icache read sees new data
        bus0.dcache_req_valid = 1'b1; bus0.dcache_req_type = 1'b1;
        bus0.dcache_req_block_addr = 29'd7; bus0.dcache_req_block_data = 64'hDEAD_BEEF_0000_0001;
        push(0, 0, 64'hDEAD_BEEF_0000_0001, cyc + 10);
        step(1, 1);
        bus0.dcache_req_valid = 1'b0;
        wait_n(10, 0, 0);
        bus0.icache_req_valid = 1'b1; bus0.icache_req_block_addr = 29'd7;
        push(0, 1, 64'hDEAD_BEEF_0000_0001, cyc + 10);
        step(1, 0);
        bus0.icache_req_valid = 1'b0;
        wait_n(10, 0, 0);
        step(1, 1);

        // Flush at T+4 cancels the icache response; a following read is served
        bus0.icache_req_valid = 1'b1; bus0.icache_req_block_addr = 29'd5;
        step(1, 0);
        bus0.icache_req_valid = 1'b0;
        wait_n(3, 0, 0);
        bus0.icache_flush = 1'b1;
        step(0, 0);
        bus0.icache_flush = 1'b0;
        wait_n(6, 0, 0);
        bus0.icache_req_valid = 1'b1; bus0.icache_req_block_addr = 29'd1;
        push(0, 1, pre_d[1], cyc + 10);
        step(1, 0);
        bus0.icache_req_valid = 1'b0;
        wait_n(10, 0, 0);
        step(1, 1);

        // Flush in the accept cycle cancels that transaction
        bus0.icache_req_valid = 1'b1; bus0.icache_req_block_addr = 29'd5; bus0.icache_flush = 1'b1;
        step(1, 0);
        bus0.icache_req_valid = 1'b0; bus0.icache_flush = 1'b0;
        wait_n(10, 0, 0);
        step(1, 1);

        // rst during a write drops it; block 9 keeps old contents; address aliasing
        bus0.dcache_req_valid = 1'b1; bus0.dcache_req_type = 1'b1;
        bus0.dcache_req_block_addr = 29'd9; bus0.dcache_req_block_data = 64'h0BAD_0BAD_0BAD_0BAD;
        step(1, 1);
        bus0.dcache_req_valid = 1'b0;
        wait_n(4, 0, 0);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        step(1, 1, 1);
        bus0.dcache_req_valid = 1'b1; bus0.dcache_req_type = 1'b0; bus0.dcache_req_block_addr = 29'd9;
        push(0, 0, pre_d[4], cyc + 10);
        step(1, 1);
        bus0.dcache_req_valid = 1'b0;
        wait_n(10, 0, 0);
        bus0.icache_req_valid = 1'b1; bus0.icache_req_block_addr = 29'(NB + 3);
        push(0, 1, pre_d[3], cyc + 10);
        step(1, 0);
        bus0.icache_req_valid = 1'b0;
        wait_n(10, 0, 0);
        step(1, 1);

        // Latency-1 build: response at T+1, next accept at T+2
        bus1.icache_req_valid = 1'b1; bus1.icache_req_block_addr = 29'd5;
        push(1, 1, pre_d[0], cyc + 1);
        step(-1, -1, 1);
        bus1.icache_req_block_addr = 29'd3;
        step(-1, -1, 0);
        push(1, 1, pre_d[3], cyc + 1);
        step(-1, -1, 1);
        bus1.icache_req_valid = 1'b0;
        step(-1, -1, 0);
        step(-1, -1, 1);

        check("dut0_scoreboard_empty", 64'(q0.size()), 64'd0);
        check("dut1_scoreboard_empty", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
- Responder side of the cache to memory-controller protocol: arbitrates block requests from the icache and the dcache and serves them from a behavioural main-memory block array.
- Returns each response after a fixed latency.
- Sits below both caches. It drives the `mem_ctrl_req_ready`, `mem_ctrl_resp_valid` and `mem_ctrl_resp_block_data` inputs of the fetch unit's icache, and the equivalent inputs of the dcache.
- Serves one transaction at a time; the icache has priority.

Parameters:
- BLOCK_WIDTH, 64, bits per memory block (`block_data_t`).
- BLOCK_ADDR_WIDTH, 29, block address width (`main_mem_block_addr_t`).
- N_BLOCKS, 1024, depth of the block array; power of 2.
- MEM_LATENCY, 10, cycles from request acceptance to response; legal range ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- init  in  1  preload mode; while high, no requests are accepted.
- init_we  in  1  array write strobe during init.
- init_block_addr  in  BLOCK_ADDR_WIDTH  preload address.
- init_block_data  in  BLOCK_WIDTH  preload data.
- icache_req_valid  in  1  icache block read request.
- icache_req_block_addr  in  BLOCK_ADDR_WIDTH  icache request address.
- icache_req_ready  out  1  icache request accepted this cycle if valid.
- icache_flush  in  1  fetch redirect; cancels an in-flight icache response.
- icache_resp_valid  out  1  icache response pulse.
- icache_resp_block_data  out  BLOCK_WIDTH  icache response data.
- dcache_req_valid  in  1  dcache request.
- dcache_req_type  in  1  `req_type_t`: READ=0, WRITE=1.
- dcache_req_block_addr  in  BLOCK_ADDR_WIDTH  dcache request address.
- dcache_req_block_data  in  BLOCK_WIDTH  write data (WRITE only).
- dcache_req_ready  out  1  dcache request accepted this cycle if valid.
- dcache_resp_valid  out  1  dcache response pulse (read data or write ack).
- dcache_resp_block_data  out  BLOCK_WIDTH  read data; write data echoed on a write ack.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset values: state=IDLE, counter=0, both resp_valid=0, both resp_block_data=0.
  - Array contents are not reset.
  - An in-flight transaction is dropped: no response, and an uncommitted write is lost.
- Readiness (combinational):
  - icache_req_ready = (state==IDLE) & ~init & ~rst.
  - dcache_req_ready = icache_req_ready & ~icache_req_valid.
- Priority: when both caches are valid in IDLE, icache wins. The dcache must hold valid, address, type and data stable until accepted.
- Accept (valid & ready at cycle T), all registered at T:
  - Latch requester, type, address and write data.
  - Load counter = MEM_LATENCY-1.
  - Go to WAIT, or directly to RESP if MEM_LATENCY==1.
- WAIT: decrement counter each cycle. When counter==1, next state is RESP.
- RESP (cycle T+MEM_LATENCY):
  - Read: the matching resp_valid is 1 for exactly that cycle, with resp_block_data = array[addr].
  - Write: the array is written at the end of that cycle, and dcache_resp_valid pulses with the echoed data.
  - Next state is always IDLE. Readies are 0 in WAIT and RESP.
- Throughput: at most one accept per MEM_LATENCY+1 cycles.
- Responses are not back-pressured; caches must sample them in the pulse cycle.
- Outside the pulse, resp_block_data returns to 0.
- icache_flush, asserted in any cycle from accept through RESP of an icache transaction:
  - Sets a cancel flag; the RESP cycle still occurs (timing unchanged) but icache_resp_valid stays 0.
  - The flag clears on return to IDLE.
  - A flush in the same cycle as an icache accept cancels that transaction.
  - A flush has no effect on dcache transactions.
- Address indexing: the array index is the low log2(N_BLOCKS) bits of the block address; upper bits alias.
- A read accepted in the cycle after a write's RESP returns the new data.
- init:
  - Never accepted mid-transaction; an in-flight transaction completes normally.
  - init_we writes array[init_block_addr] at the clock edge.
- rst has priority over init, requests and flush.

Test Plan:
- Preload block 5 = 0x1111_2222_3333_4444; icache reads 5 at T -> icache_resp_valid=1 only at T+10, data 0x1111_2222_3333_4444; ready returns at T+11.
- icache (addr 1) and dcache READ (addr 2) valid at T -> icache accepted at T, dcache_req_ready=0 through T+10, dcache accepted at T+11, dcache_resp_valid at T+21.
- dcache WRITE addr 7 data 0xDEAD_BEEF_0000_0001 at T -> ack with echoed data at T+10; icache read of 7 at T+11 returns 0xDEAD_BEEF_0000_0001 at T+21.
- icache read at T, icache_flush at T+4 -> no icache_resp_valid through T+10; ready=1 at T+11; a new icache read is then served normally.
- dcache WRITE addr 9 at T, rst at T+5 -> no dcache_resp_valid, ready=1 the cycle after rst drops, a read of 9 returns its prior contents; read of addr N_BLOCKS+3 returns array[3].
- MEM_LATENCY=1 build: icache read at T -> resp at T+1, next accept at T+2.
